conv_1g_rx_reader: RTL

CONV_1G_RX_READER -- requirements
Module: conv_1G_rx_reader

---
 rtl/conv_1g_rx_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/conv_1g_rx_reader.sv
// 1G RX word-FIFO reader: frames the showahead FIFO stream into a ready/valid
// packet stream with orphan dropping, truncation and missing-eop repair.
module conv_1g_rx_reader #(
  parameter int unsigned MAX_WORDS = 190
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        pkt_avail_i,
  input  logic [63:0] pkt_data_i,
  input  logic        pkt_sop_i,
  input  logic        pkt_eop_i,
  input  logic        frame_crc_err_i,
  input  logic [2:0]  pkt_mod_i,
  output logic        fifo_rd_req_o,
  output logic [63:0] data_o,
  output logic        sop_o,
  output logic        eop_o,
  output logic [2:0]  mod_o,
  output logic        err_o,
  output logic        val_o,
  input  logic        ready_i,
  output logic [31:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t      state, n_state;
  logic [15:0] cnt, n_cnt;
  logic        slot_free, pop, load, drop;
  logic [63:0] ld_data;
  logic        ld_sop, ld_eop, ld_err;
  logic [2:0]  ld_mod;
  logic        last_word;

  assign slot_free = !val_o || ready_i;
  assign last_word = ({1'b0, cnt} + 17'd1) == 17'(MAX_WORDS);
  // gated so nothing is popped while reset holds the block
  assign fifo_rd_req_o = pop && rst_n_i;

  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    pop     = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    ld_data = pkt_data_i;
    ld_sop  = 1'b0;
    ld_eop  = 1'b0;
    ld_mod  = 3'd0;
    ld_err  = 1'b0;
    if (pkt_avail_i) begin
      case (state)
        IDLE: begin
          if (!pkt_sop_i) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else if (slot_free) begin
            pop    = 1'b1;
            load   = 1'b1;
            ld_sop = 1'b1;
            if (pkt_eop_i) begin
              ld_eop = 1'b1;
              ld_mod = pkt_mod_i;
              ld_err = frame_crc_err_i;
            end else begin
              n_cnt   = 16'd1;
              n_state = PKT;
            end
          end
        end
        PKT: begin
          if (slot_free) begin
            load = 1'b1;
            if (pkt_sop_i) begin
              // missing eop: close the open packet without consuming the new sop
              ld_data = '0;
              ld_eop  = 1'b1;
              ld_err  = 1'b1;
              n_state = IDLE;
            end else begin
              pop = 1'b1;
              if (pkt_eop_i) begin
                ld_eop  = 1'b1;
                ld_mod  = pkt_mod_i;
                ld_err  = frame_crc_err_i;
                n_state = IDLE;
              end else if (last_word) begin
                ld_eop  = 1'b1;
                ld_err  = 1'b1;
                n_state = DROP;
              end else begin
                n_cnt = cnt + 16'd1;
              end
            end
          end
        end
        DROP: begin
          if (pkt_sop_i) begin
            n_state = IDLE;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
            if (pkt_eop_i) n_state = IDLE;
          end
        end
        default: n_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= n_state;
      cnt   <= n_cnt;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      val_o      <= 1'b0;
      data_o     <= '0;
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
      mod_o      <= '0;
      err_o      <= 1'b0;
      pkt_cnt_o  <= '0;
      err_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (load) begin
        val_o  <= 1'b1;
        data_o <= ld_data;
        sop_o  <= ld_sop;
        eop_o  <= ld_eop;
        mod_o  <= ld_mod;
        err_o  <= ld_err;
      end else if (ready_i) begin
        val_o <= 1'b0;
      end
      if (val_o && ready_i && eop_o) begin
        if (pkt_cnt_o != '1) pkt_cnt_o <= pkt_cnt_o + 32'd1;
        if (err_o && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 16'd1;
      end
      if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

endmodule
